priority_grant_scheduler: RTL and testbench
===========================================

Name: priority_grant_scheduler

Overview:
- Collects single-cycle request pulses from DATA_WIDTH sources into a pending vector.
- Selects one pending source by fixed priority (highest index wins) and presents its index on a registered valid/ready grant interface.
- Clears the served bit once the grant is accepted.
- Sits downstream of the priority-encoder stage. It turns the combinational index into a stateful, back-pressured grant stream for the consumer datapath.

Parameters:
- DATA_WIDTH, 8, number of request sources; legal range 2..64.
- CNT_WIDTH, 16, width of the merge counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  DATA_WIDTH  request pulses; bit k high for one cycle means source k requests.
- grant_idx_o  output  $clog2(DATA_WIDTH)  index of granted source; registered.
- grant_valid_o  output  1  grant_idx_o holds a valid grant; registered.
- grant_ready_i  input  1  consumer accepts the grant this cycle.
- pending_o  output  DATA_WIDTH  registered pending vector, excluding the bit currently offered.
- merge_cnt_o  output  CNT_WIDTH  saturating count of requests merged into an already-pending bit.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high. On reset assertion, immediately:
  - pending = 0, grant_idx_o = 0, grant_valid_o = 0, merge_cnt_o = 0, FSM = IDLE.
- Width: IDX_W = $clog2(DATA_WIDTH).
- Pending update, every cycle: pending_next = (pending & ~sel_mask) | req_i.
  - sel_mask is the one-hot of the index loaded into the grant register this cycle; otherwise 0.
  - A request on the bit being selected in the same cycle wins. The bit stays pending and is served again later.
- Selection: the highest set bit of pending wins. Only registered pending is used; req_i is never selected combinationally.
- FSM states: IDLE and OFFER.
  - IDLE, pending != 0: load grant_idx_o with the selected index, set grant_valid_o = 1, clear that bit from pending, go to OFFER.
  - IDLE, pending == 0: stay in IDLE.
  - OFFER, grant_ready_i = 0: grant_idx_o and grant_valid_o held stable. No change allowed until acceptance.
  - OFFER, grant_ready_i = 1 and pending != 0: back-to-back. Load the next selected index, keep grant_valid_o = 1, clear that bit, stay in OFFER.
  - OFFER, grant_ready_i = 1 and pending == 0: grant_valid_o = 0, go to IDLE. grant_idx_o holds its last value.
- Latency: req_i at cycle N gives pending at N+1 and grant_valid_o at N+2 when IDLE. Sustained throughput is one grant per cycle while grant_ready_i = 1.
- Offered index re-requested while in OFFER: the bit is set in pending again and is served after the current grant is accepted.
- merge_cnt_o: increments by popcount(req_i & pending) each cycle and saturates at all-ones. The currently offered bit is not part of pending, so it does not count as a merge.
- grant_ready_i is ignored when grant_valid_o = 0.
- Mid-operation reset: any outstanding grant and all pending bits are dropped. grant_valid_o falls asynchronously.

Optional Feature:
- Macro: PRIORITY_GRANT_SCHEDULER_ROUND_ROBIN_EN.
- Defined: round-robin selection.
  - A last-grant pointer (IDX_W bits, reset 0) updates on every grant load.
  - Selection picks the highest set pending bit strictly below the pointer, wrapping from 0 to DATA_WIDTH-1.
  - If the only pending bit equals the pointer, it is selected.
- Undefined: fixed highest-index priority. No pointer register is built.

Test Plan (DATA_WIDTH=8; in round-robin mode the pointer resets to 0):
1. Reset, then req_i=8'h00 for 10 cycles -> grant_valid_o=0, pending_o=0, merge_cnt_o=0 throughout.
2. req_i=8'h29 for one cycle, grant_ready_i=1 -> grants 5, 3, 0 on consecutive cycles starting 2 cycles after the request, then grant_valid_o=0.
3. req_i=8'h81, grant_ready_i=0 for 4 cycles, then 1 -> grant_idx_o=7 held stable for 4 cycles, pending_o=8'h01; then grant 0.
4. While idx 7 is offered, pulse req_i=8'h80 and req_i=8'h01 with pending 8'h01 -> pending_o=8'h81 and merge_cnt_o=1; after acceptance, grants 7 then 0.
5. Assert rst_i mid-offer with pending_o=8'h0C -> grant_valid_o=0 and pending_o=0 before the next clock edge.
6. ROUND_ROBIN_EN defined, req_i=8'hFF held for 3 cycles, grant_ready_i=1 -> grants 7, 6, 5, 4, ... ; no source repeats within 8 grants.
   - Macro undefined, same stimulus -> grant 7 every cycle while re-requested.

Source files
------------

// File: rtl/priority_grant_scheduler.sv
// rtl/priority_grant_scheduler.sv - pending-request collector with registered valid/ready grant output.
// Optional PRIORITY_GRANT_SCHEDULER_ROUND_ROBIN_EN selects round-robin instead of fixed highest-index priority.
module priority_grant_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] req_i,
  output logic [IDX_W-1:0]      grant_idx_o,
  output logic                  grant_valid_o,
  input  logic                  grant_ready_i,
  output logic [DATA_WIDTH-1:0] pending_o,
  output logic [CNT_WIDTH-1:0]  merge_cnt_o
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  pending, sel_mask;
  logic [IDX_W-1:0]       sel;
  logic                   load;
  logic [6:0]             merge_inc;
  logic [CNT_WIDTH+7:0]   merge_sum;

`ifdef PRIORITY_GRANT_SCHEDULER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;
  logic             below_found;

  // Highest pending index strictly below the pointer; otherwise wrap to the top and search down to the pointer.
  always_comb begin
    sel         = '0;
    below_found = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (pending[i] && (IDX_W'(i) < ptr)) begin
        sel         = IDX_W'(i);
        below_found = 1'b1;
      end
    end
    if (!below_found) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (pending[i] && (IDX_W'(i) >= ptr)) sel = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     ptr <= '0;
    else if (load) ptr <= sel;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (pending[i]) sel = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          load       = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (grant_ready_i) begin
          if (|pending) load = 1'b1;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sel_mask = load ? (DATA_WIDTH'(1) << sel) : '0;

  always_comb begin
    merge_inc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      merge_inc = merge_inc + {6'd0, req_i[i] & pending[i]};
    end
    merge_sum = (CNT_WIDTH+8)'(merge_cnt_o) + (CNT_WIDTH+8)'(merge_inc);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      pending       <= '0;
      grant_idx_o   <= '0;
      grant_valid_o <= 1'b0;
      merge_cnt_o   <= '0;
    end else begin
      state         <= state_next;
      pending       <= (pending & ~sel_mask) | req_i;
      grant_valid_o <= (state_next == OFFER);
      if (load) grant_idx_o <= sel;
      // Saturate rather than wrap so a long run of merges never reads as few.
      if (merge_sum > (CNT_WIDTH+8)'({CNT_WIDTH{1'b1}})) merge_cnt_o <= '1;
      else                                                merge_cnt_o <= merge_sum[CNT_WIDTH-1:0];
    end
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_priority_grant_scheduler.sv
// tb/tb_priority_grant_scheduler.sv - scoreboard bench for priority_grant_scheduler against a behavioural model.
module tb_priority_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  req_i;
  logic [2:0]  grant_idx_o;
  logic        grant_valid_o;
  logic        grant_ready_i;
  logic [7:0]  pending_o;
  logic [15:0] merge_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  bit [7:0] m_pend;
  bit       m_ov;
  int       m_oi;
  int       m_ptr;
  int       m_cnt;
  int       exp_q[$];

  priority_grant_scheduler #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .grant_idx_o   (grant_idx_o),
    .grant_valid_o (grant_valid_o),
    .grant_ready_i (grant_ready_i),
    .pending_o     (pending_o),
    .merge_cnt_o   (merge_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef PRIORITY_GRANT_SCHEDULER_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (m_ptr - k + 8) % 8;
      if (m_pend[c]) return c;
    end
`else
    for (int c = 7; c >= 0; c--) if (m_pend[c]) return c;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ov = 0; m_oi = 0; m_ptr = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // One clock of the reference: a new grant is taken whenever the output slot is free or being freed.
  task automatic model_advance(input bit [7:0] r, input bit rd);
    int s;
    m_cnt = m_cnt + $countones(r & m_pend);
    if (m_cnt > 65535) m_cnt = 65535;
    if ((!m_ov || rd) && m_pend != 0) begin
      s = pick();
      exp_q.push_back(s);
      m_pend = (m_pend & ~(8'b1 << s)) | r;
      m_ov   = 1;
      m_oi   = s;
      m_ptr  = s;
    end else begin
      m_pend = m_pend | r;
      if (m_ov && rd) m_ov = 0;
    end
  endtask

  task automatic check_outputs();
    chk("grant_valid", 64'(grant_valid_o), 64'(m_ov));
    chk("grant_idx",   64'(grant_idx_o),   64'(m_oi));
    chk("pending",     64'(pending_o),     64'(m_pend));
    chk("merge_cnt",   64'(merge_cnt_o),   64'(m_cnt));
  endtask

  // Called 2 time units after a rising edge; inputs then hold through the next edge.
  task automatic step(input logic [7:0] r, input logic rd);
    check_outputs();
    req_i         = r;
    grant_ready_i = rd;
    model_advance(r, rd);
    @(posedge clk); #2;
  endtask

  always @(negedge clk) begin
    if (!rst_i && grant_valid_o && grant_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", 64'(grant_idx_o), 64'hFFFF);
      end else begin
        chk("grant_order", 64'(grant_idx_o), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_i = 1'b1; req_i = '0; grant_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_outputs();
    rst_i = 1'b0;

    // Idle: nothing pending, nothing offered
    for (int i = 0; i < 10; i++) step(8'h00, 1'($urandom_range(0, 1)));

    // Three requests in one pulse, consumer always ready
    step(8'h29, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1);

    // Back-pressure holds the offer
    step(8'h81, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);

    // Offered index re-requested, plus a merge into pending bit 0
    step(8'h81, 1'b0);
    step(8'h00, 1'b0);
    step(8'h80, 1'b0);
    step(8'h01, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1);

    // Asynchronous reset while offering with bits still pending
    step(8'h8C, 1'b0);
    step(8'h00, 1'b0);
    check_outputs();
    rst_i = 1'b1;
    #1;
    chk("rst_async_valid",   64'(grant_valid_o), 64'd0);
    chk("rst_async_pending", 64'(pending_o),     64'd0);
    @(posedge clk); #2;
    rst_i = 1'b0;
    model_reset();

    // All sources requesting for three cycles
    for (int i = 0; i < 3; i++) step(8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) step(8'h00, 1'b1);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(r, 1'($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 12; i++) step(8'h00, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
